// File: rtl/act_mem_pkg.sv
// Shared types for the activation-memory loader and the layer-side index readers.
package act_mem_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    GO,
    WAIT,
    DONE
  } loader_state_t;

  // [2]=entry, [1]=y, [0]=x
  typedef logic [2:0][IDX_W-1:0] act_index_t;

endpackage

// File: rtl/act_mem_loader_if.sv
// Activation stream in, layer-memory write port and layer go/done handshake out.
interface act_mem_loader_if #(
    parameter int DATA_SIZE = 64
);
    import act_mem_pkg::*;

    // A word transfers on a rising edge where in_valid && in_ready; in_valid and
    // in_data must hold until that edge, in_ready never depends on in_valid.
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;

    logic                 inmem_want_write;
    logic [DATA_SIZE-1:0] inmem_write_data;
    act_index_t           inmem_index;

    logic                 layer_go;
    logic                 layer_done;

    modport master (
        input  in_valid, in_data, layer_done,
        output in_ready, inmem_want_write, inmem_write_data, inmem_index, layer_go
    );

    modport slave (
        output in_valid, in_data, layer_done,
        input  in_ready, inmem_want_write, inmem_write_data, inmem_index, layer_go
    );

endinterface

// File: rtl/act_index_counter.sv
// Raster-order x/y/entry counter: x fastest, then y, then entry; last flags the final position.
module act_index_counter
    import act_mem_pkg::*;
#(
    parameter int DIM        = 5,
    parameter int NUM_INPUTS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic [IDX_W-1:0] entry,
    output logic             last
);

    localparam logic [IDX_W-1:0] XY_MAX = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] E_MAX  = IDX_W'(NUM_INPUTS - 1);

    logic [IDX_W-1:0] x_q, x_d, y_q, y_d, entry_q, entry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            entry_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        entry_d = entry_q;
        if (clear) begin
            x_d     = '0;
            y_d     = '0;
            entry_d = '0;
        end else if (inc) begin
            if (x_q == XY_MAX) begin
                x_d = '0;
                if (y_q == XY_MAX) begin
                    y_d     = '0;
                    entry_d = (entry_q == E_MAX) ? '0 : entry_q + IDX_W'(1);
                end else begin
                    y_d = y_q + IDX_W'(1);
                end
            end else begin
                x_d = x_q + IDX_W'(1);
            end
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign entry = entry_q;
    assign last  = (x_q == XY_MAX) && (y_q == XY_MAX) && (entry_q == E_MAX);

endmodule

// File: rtl/act_mem_loader.sv
// Loads one frame of activations into a layer's memory in raster order, then
// fires layer_go and waits for the layer to report done (optionally with a timeout).
module act_mem_loader
    import act_mem_pkg::*;
#(
    parameter string NAME       = "ACTLOAD_DEFAULT_NAME",
    parameter int    NUM_INPUTS = 1,
    parameter int    DIM        = 5,
    parameter int    DATA_SIZE  = 64,
    parameter int    TIMEOUT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    act_mem_loader_if.master         bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err,
    output loader_state_t            dbg_state
);

    loader_state_t        state_q, state_d;
    logic                 accept;
    logic                 cnt_clear;
    logic                 cnt_last;
    logic [IDX_W-1:0]     cnt_x, cnt_y, cnt_entry;
    logic                 timeout_hit;

    logic                 wr_q, wr_d;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    act_index_t           wr_idx_q, wr_idx_d;
    logic [31:0]          wait_cnt_q, wait_cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    assign accept      = bus.in_valid && bus.in_ready;
    assign cnt_clear   = (state_q == IDLE) && start;
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == 32'(TIMEOUT - 1));

    act_index_counter #(
        .DIM        (DIM),
        .NUM_INPUTS (NUM_INPUTS)
    ) u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (accept),
        .x     (cnt_x),
        .y     (cnt_y),
        .entry (cnt_entry),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept && cnt_last) state_d = FLUSH;
            FLUSH:   state_d = GO;
            GO:      state_d = WAIT;
            WAIT: begin
                // A real done wins over a timeout landing in the same cycle.
                if (bus.layer_done)   state_d = DONE;
                else if (timeout_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == LOAD);
        bus.layer_go = (state_q == GO);
        busy         = (state_q != IDLE);
        frame_done   = (state_q == DONE);
        dbg_state    = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q          <= 1'b0;
            wr_data_q     <= '0;
            wr_idx_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wr_q          <= wr_d;
            wr_data_q     <= wr_data_d;
            wr_idx_q      <= wr_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        wr_d          = accept;
        wr_data_d     = accept ? bus.in_data : wr_data_q;
        wr_idx_d      = accept ? {cnt_entry, cnt_y, cnt_x} : wr_idx_q;
        wait_cnt_d    = (state_q == WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
        timeout_err_d = timeout_err_q;
        if (cnt_clear) begin
            timeout_err_d = 1'b0;
        end else if ((state_q == WAIT) && !bus.layer_done && timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    assign bus.inmem_want_write = wr_q;
    assign bus.inmem_write_data = wr_data_q;
    assign bus.inmem_index      = wr_idx_q;
    assign timeout_err          = timeout_err_q;

    // The last write drains in FLUSH, so the memory is never written while the layer starts.
    assert property (@(posedge clk) disable iff (!rst_n) !(bus.layer_go && bus.inmem_want_write))
        else $error("%s: memory write overlaps layer_go", NAME);

endmodule

// File: tb/tb_act_mem_loader.sv
// Bench for act_mem_loader: three instances (3x3x1, 2x2x2 with timeout, 1x1x1)
// driven one at a time against a raster-order reference of the expected writes.
module tb_act_mem_loader;
  import act_mem_pkg::*;

  localparam int DW = 16;
  localparam int W  = 3 * IDX_W + DW;
  localparam int NI [3] = '{1, 2, 1};
  localparam int DM [3] = '{3, 2, 1};
  localparam int TO [3] = '{0, 10, 0};

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start, in_valid, layer_done;
  logic [DW-1:0] in_data [3];
  logic [2:0] in_ready, want, layer_go, busy, frame_done, timeout_err;
  logic [DW-1:0] wdata [3];
  act_index_t widx [3];
  loader_state_t dstate [3];

  logic [DW-1:0] src_q [$];
  logic [W-1:0]  exp_q [$];
  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    act_mem_loader_if #(.DATA_SIZE(DW)) bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_data    = in_data[g];
    assign bus.layer_done = layer_done[g];
    assign in_ready[g]    = bus.in_ready;
    assign want[g]        = bus.inmem_want_write;
    assign wdata[g]       = bus.inmem_write_data;
    assign widx[g]        = bus.inmem_index;
    assign layer_go[g]    = bus.layer_go;

    act_mem_loader #(
      .NAME       ("tb_loader"),
      .NUM_INPUTS (NI[g]),
      .DIM        (DM[g]),
      .DATA_SIZE  (DW),
      .TIMEOUT    (TO[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start[g]),
      .bus         (bus),
      .busy        (busy[g]),
      .frame_done  (frame_done[g]),
      .timeout_err (timeout_err[g]),
      .dbg_state   (dstate[g])
    );
  end

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the expected write sequence of one frame, in raster order.
  task automatic plan_frame(input int ni, input int dm, input bit seq);
    int n;
    logic [DW-1:0] dat;
    src_q.delete();
    exp_q.delete();
    n = 0;
    for (int e = 0; e < ni; e++)
      for (int y = 0; y < dm; y++)
        for (int x = 0; x < dm; x++) begin
          dat = seq ? DW'(n + 1) : DW'($urandom);
          n++;
          src_q.push_back(dat);
          exp_q.push_back({IDX_W'(e), IDX_W'(y), IDX_W'(x), dat});
        end
  endtask

  // Called at a negedge; returns at the negedge where the loader is in LOAD.
  task automatic do_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Streams src_q with random gaps, scoreboarding every write; returns at the GO negedge.
  task automatic load_frame(input int d, input int gap);
    logic acc;
    logic [W-1:0] e;
    int cyc;
    acc = 1'b0;
    for (cyc = 0; cyc < 500; cyc++) begin
      tests++;
      if (want[d] !== acc) begin
        fails++;
        $display("FAIL write_strobe dut%0d cyc%0d: got %b expected %b", d, cyc, want[d], acc);
      end
      if (want[d] === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_write dut%0d: got idx %h data %h, expected none", d, widx[d], wdata[d]);
        end else begin
          e = exp_q.pop_front();
          if ({widx[d], wdata[d]} !== e) begin
            fails++;
            $display("FAIL write_word dut%0d: got %h expected %h", d, {widx[d], wdata[d]}, e);
          end
        end
      end
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      in_valid[d] = (src_q.size() != 0) && ($urandom_range(99) >= gap);
      in_data[d]  = in_valid[d] ? src_q[0] : DW'($urandom);
      acc = in_valid[d] && in_ready[d];
      if (acc) void'(src_q.pop_front());
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    tests++;
    if (cyc >= 500) begin
      fails++;
      $display("FAIL load_budget dut%0d: %0d writes still missing, expected 0", d, exp_q.size());
    end
    tests++;
    if (in_ready[d] !== 1'b0 || layer_go[d] !== 1'b0) begin
      fails++;
      $display("FAIL flush dut%0d: in_ready %b layer_go %b, expected 0 0", d, in_ready[d], layer_go[d]);
    end
    @(negedge clk);
    tests++;
    if (layer_go[d] !== 1'b1 || want[d] !== 1'b0) begin
      fails++;
      $display("FAIL go_pulse dut%0d: layer_go %b write %b, expected 1 0", d, layer_go[d], want[d]);
    end
  endtask

  // From the GO negedge: one WAIT cycle, a done pulse, then back to IDLE.
  task automatic finish_frame(input int d);
    layer_done[d] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy[d] !== 1'b1 || frame_done[d] !== 1'b0 || layer_go[d] !== 1'b0) begin
      fails++;
      $display("FAIL wait_state dut%0d: busy %b frame_done %b layer_go %b, expected 1 0 0",
               d, busy[d], frame_done[d], layer_go[d]);
    end
    layer_done[d] = 1'b1;
    @(negedge clk);
    layer_done[d] = 1'b0;
    tests++;
    if (frame_done[d] !== 1'b1) begin
      fails++;
      $display("FAIL frame_done dut%0d: got %b expected 1", d, frame_done[d]);
    end
    @(negedge clk);
    tests++;
    if (busy[d] !== 1'b0 || frame_done[d] !== 1'b0) begin
      fails++;
      $display("FAIL back_idle dut%0d: busy %b frame_done %b, expected 0 0", d, busy[d], frame_done[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = '0;
    in_valid = '0;
    layer_done = '0;
    for (int d = 0; d < 3; d++) in_data[d] = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({want[d], in_ready[d], layer_go[d], busy[d], frame_done[d], timeout_err[d]} !== 6'b0 ||
          widx[d] !== '0 || wdata[d] !== '0 || dstate[d] !== IDLE) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: ctl %b idx %h data %h, expected all zero", d,
                 {want[d], in_ready[d], layer_go[d], busy[d], frame_done[d], timeout_err[d]},
                 widx[d], wdata[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (want !== 3'b000 || in_ready !== 3'b000) begin
        fails++;
        $display("FAIL idle_no_accept: write %b in_ready %b, expected 000 000", want, in_ready);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_stream_full();
    plan_frame(1, 3, 1'b1);
    do_start(0);
    load_frame(0, 0);
    finish_frame(0);
  endtask

  task automatic test_gaps_back_to_back();
    for (int f = 0; f < 2; f++) begin
      plan_frame(2, 2, 1'b0);
      do_start(1);
      load_frame(1, 40);
      finish_frame(1);
    end
  endtask

  task automatic test_done_filter();
    plan_frame(1, 3, 1'b0);
    do_start(0);
    layer_done[0] = 1'b1;
    load_frame(0, 25);
    @(negedge clk);
    layer_done[0] = 1'b0;
    tests++;
    if (dstate[0] !== WAIT || frame_done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL early_done_ignored: state %0d frame_done %b, expected WAIT 0", dstate[0], frame_done[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (frame_done[0] !== 1'b0 || busy[0] !== 1'b1) begin
        fails++;
        $display("FAIL wait_hold: frame_done %b busy %b, expected 0 1", frame_done[0], busy[0]);
      end
    end
    layer_done[0] = 1'b1;
    @(negedge clk);
    layer_done[0] = 1'b0;
    tests++;
    if (frame_done[0] !== 1'b1 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: frame_done %b busy %b, expected 1 1", frame_done[0], busy[0]);
    end
    @(negedge clk);
    tests++;
    if (frame_done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL done_release: frame_done %b busy %b, expected 0 0", frame_done[0], busy[0]);
    end
  endtask

  task automatic test_timeout();
    plan_frame(2, 2, 1'b0);
    do_start(1);
    load_frame(1, 20);
    layer_done[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      tests++;
      if (busy[1] !== 1'b1 || timeout_err[1] !== 1'b0 || frame_done[1] !== 1'b0) begin
        fails++;
        $display("FAIL wait_cycle%0d: busy %b err %b frame_done %b, expected 1 0 0",
                 i, busy[1], timeout_err[1], frame_done[1]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (dstate[1] !== IDLE || timeout_err[1] !== 1'b1 || frame_done[1] !== 1'b0) begin
        fails++;
        $display("FAIL timeout_idle: state %0d err %b frame_done %b, expected IDLE 1 0",
                 dstate[1], timeout_err[1], frame_done[1]);
      end
    end
    plan_frame(2, 2, 1'b0);
    do_start(1);
    tests++;
    if (timeout_err[1] !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: err %b, expected 0", timeout_err[1]);
    end
    load_frame(1, 0);
    finish_frame(1);
  endtask

  task automatic test_reset_mid_load();
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = DW'($urandom);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    tests++;
    if (want[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_write: got %b expected 1", want[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (want[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0 ||
        widx[0] !== '0 || wdata[0] !== '0 || dstate[0] !== IDLE) begin
      fails++;
      $display("FAIL async_reset: write %b busy %b idx %h data %h, expected all zero",
               want[0], busy[0], widx[0], wdata[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    plan_frame(1, 3, 1'b0);
    do_start(0);
    load_frame(0, 30);
    finish_frame(0);
  endtask

  task automatic test_single_pixel_restart_ignored();
    plan_frame(1, 1, 1'b0);
    start[2] = 1'b1;
    @(negedge clk);
    load_frame(2, 0);
    finish_frame(2);
    start[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (busy[2] !== 1'b0 || frame_done[2] !== 1'b0 || want[2] !== 1'b0) begin
        fails++;
        $display("FAIL second_start_ignored: busy %b frame_done %b write %b, expected 0 0 0",
                 busy[2], frame_done[2], want[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_full();
    test_gaps_back_to_back();
    test_done_filter();
    test_timeout();
    test_reset_mid_load();
    test_single_pixel_restart_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
